// File: rtl/gate_shift_unit.sv
// Bitwise logic unit followed by a one-bit-per-cycle shifter, driven by a
// start/busy/done handshake. Operands are captured on start; result holds between completions.
module gate_shift_unit #(
  parameter  int WIDTH   = 8,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               dir,
  input  logic               arith,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOGIC,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             state, state_next;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [SHAMT_W-1:0] shamt_q, cnt;
  logic               dir_q, arith_q;
  logic [WIDTH-1:0]   acc, acc_next;
  logic [WIDTH-1:0]   logic_res, shifted;
  logic               capture;

  always_comb begin
    logic_res = a_q;
    case (op_q)
      3'b000:  logic_res = a_q & b_q;
      3'b001:  logic_res = a_q | b_q;
      3'b010:  logic_res = ~(a_q & b_q);
      3'b011:  logic_res = ~(a_q | b_q);
      3'b100:  logic_res = a_q ^ b_q;
      3'b101:  logic_res = ~(a_q ^ b_q);
      3'b110:  logic_res = ~a_q;
      default: logic_res = a_q;
    endcase
  end

  always_comb begin
    shifted = {acc[WIDTH-2:0], 1'b0};
    if (dir_q)
      shifted = {(arith_q & acc[WIDTH-1]), acc[WIDTH-1:1]};
  end

  always_comb begin
    state_next = state;
    acc_next   = acc;
    capture    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          capture    = 1'b1;
          state_next = S_LOGIC;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_LOGIC: begin
        acc_next   = logic_res;
        state_next = (shamt_q == '0) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        acc_next = shifted;
        if (cnt == SHAMT_W'(1))
          state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      acc     <= '0;
      cnt     <= '0;
      result  <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      shamt_q <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      if (capture) begin
        op_q    <= op;
        a_q     <= a;
        b_q     <= b;
        shamt_q <= shamt;
        dir_q   <= dir;
        arith_q <= arith;
      end
      if (state == S_LOGIC)
        cnt <= shamt_q;
      else if (state == S_SHIFT)
        cnt <= cnt - SHAMT_W'(1);
      // Result takes the value acc is about to get, so it lands on DONE entry.
      if (state_next == S_DONE)
        result <= acc_next;
    end
  end

  assign busy = (state == S_LOGIC) || (state == S_SHIFT);
  assign done = (state == S_DONE);

endmodule
